i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
- I2S master transmitter for the S3 FPGA fabric; the transmit-side counterpart of the fabric I2S receive path.
- Buffers stereo frames pushed by a Wishbone register or SDMA front-end, divides the IP clock down to the I2S bit clock, and drives the bit clock, word select and serial data onto FBIO.
- Raises a sticky underrun interrupt, which feeds the FB_msg_out interrupt OR tree.

Parameters:
DATA_WIDTH, 16, bits per channel; frame = 2*DATA_WIDTH bit clocks
CLK_DIV, 4, CLK_IP_i cycles per I2S bit clock; even, >=2
FIFO_DEPTH, 4, frame FIFO entries; power of 2, >=2

Ports:
CLK_IP_i  in  1  fabric IP clock; sole clock
RST_IP_N_i  in  1  asynchronous, active-low reset
TX_EN_i  in  1  transmit enable (level)
TX_DAT_i  in  2*DATA_WIDTH  frame {left[W-1:0], right[W-1:0]}
TX_PUSH_i  in  1  one-cycle write strobe
TX_FULL_o  out  1  FIFO full
TX_EMPTY_o  out  1  FIFO empty
TX_LEVEL_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
UNDERRUN_CLR_i  in  1  clears underrun interrupt
I2S_Underrun_Intr_o  out  1  sticky underrun interrupt
I2S_TX_Busy_o  out  1  serializer active
I2S_CLK_o  out  1  bit clock
I2S_WS_CLK_o  out  1  word select; 0 = left, 1 = right
I2S_DOUT_o  out  1  serial data, MSB first

Behaviour:
- Reset (async, RST_IP_N_i=0):
  - All outputs 0; TX_EMPTY_o=1.
  - FIFO emptied, state IDLE, divider and position counter cleared.
  - Applies mid-frame without completing the frame.
- FIFO:
  - TX_PUSH_i with !TX_FULL_o writes TX_DAT_i; level +1 next cycle.
  - Push while full is dropped and the contents are unchanged, even if a pop occurs in the same cycle.
  - Simultaneous push (not full) and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider:
  - In RUN/STOP, the counter toggles I2S_CLK_o every CLK_DIV/2 cycles.
  - A "fall event" is the cycle in which I2S_CLK_o is driven 1->0.
  - In IDLE, the counter is held at 0 and I2S_CLK_o=0.
- Shift register sh[2W-1:0]; frame position p, 0..2W-1.
- States:
  - IDLE -> RUN on the first cycle TX_EN_i=1. In that cycle: p=0, WS=0, DOUT=0, and the frame is loaded (pop, or zeros plus underrun if empty). The first SCK rise occurs CLK_DIV/2 cycles later.
  - RUN, each fall event:
    - DOUT <= sh[2W-1]; sh <<= 1; p <= p+1 (wrapping).
    - WS <= (p_next >= W).
    - When p wraps to 0: reload sh (pop, or zeros plus underrun if empty) after the old MSB has been captured into DOUT.
    - Net effect: left MSB appears at p=1 and right LSB at the next frame's p=0, which is the standard one-bit I2S delay.
  - RUN -> STOP: at the wrap fall event if TX_EN_i=0. No pop occurs; DOUT carries right LSB; WS=0.
  - STOP -> IDLE: at the next fall event. SCK stays 0, DOUT=0, WS=0.
  - TX_EN_i deasserted mid-frame: the current frame completes; there is no truncation.
  - TX_EN_i reasserted during STOP is ignored until IDLE is reached.
- I2S_TX_Busy_o = (state != IDLE).
- Underrun:
  - I2S_Underrun_Intr_o sets the cycle after a load finds the FIFO empty.
  - Cleared by UNDERRUN_CLR_i.
  - Set and clear in the same cycle: set wins.
- FIFO contents persist across enable cycles.

Optional Feature:
I2S_TX_HOLD_LAST_EN:
- Defined: an underrun load repeats the last frame popped (zeros if nothing has been popped since reset). The interrupt still sets.
- Undefined: an underrun load sends zeros.

Test Plan:
1. CLK_DIV=4, W=16. Push 0xA5A5_3C3C, then TX_EN_i=1 -> SCK period 4 cycles; WS low p0-15, high p16-31; DOUT serial 1010_0101_1010_0101 from p1, then 0011_1100_0011_1100 from p17; LSB 0 at next p0.
2. Push 4 frames with TX_EN_i=0 -> TX_FULL_o=1, TX_LEVEL_o=4. Fifth push dropped. Enable -> frames transmitted in order; TX_EMPTY_o=1 after the 4th load.
3. Enable with an empty FIFO -> DOUT all 0 and I2S_Underrun_Intr_o=1 one cycle after the load. UNDERRUN_CLR_i pulse -> 0. Clear coincident with a new underrun -> stays 1. With I2S_TX_HOLD_LAST_EN defined, the last frame is repeated instead.
4. Drop TX_EN_i at p=10 -> frame completes; one extra SCK with right LSB; then SCK/WS/DOUT=0 and I2S_TX_Busy_o=0. The next queued frame is not popped.
5. Assert RST_IP_N_i=0 at p=20 -> all outputs 0 asynchronously, FIFO empty. Release, push, enable -> clean frame starting at p=0.
6. Push and pop in the same cycle at level 2 -> level stays 2. At full, push is dropped while pop proceeds -> level 3.

Source files
------------

// File: rtl/i2s_tx_master_if.sv
// Push-side bus of the I2S transmitter: frame data and write strobe in, FIFO status out.
interface i2s_tx_master_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned FW = 2 * DATA_WIDTH;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [FW-1:0] TX_DAT_i;
  logic          TX_PUSH_i;
  logic          TX_FULL_o;
  logic          TX_EMPTY_o;
  logic [LW-1:0] TX_LEVEL_o;

  modport master (
    output TX_DAT_i,
    output TX_PUSH_i,
    input  TX_FULL_o,
    input  TX_EMPTY_o,
    input  TX_LEVEL_o
  );

  modport slave (
    input  TX_DAT_i,
    input  TX_PUSH_i,
    output TX_FULL_o,
    output TX_EMPTY_o,
    output TX_LEVEL_o
  );
endinterface

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: frame FIFO, bit-clock divider and MSB-first serializer with one-bit WS delay.
// Optional I2S_TX_HOLD_LAST_EN: an underrun load repeats the last popped frame instead of zeros.
module i2s_tx_master #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           CLK_IP_i,
  input  logic           RST_IP_N_i,
  i2s_tx_master_if.slave tx_if,
  input  logic           TX_EN_i,
  input  logic           UNDERRUN_CLR_i,
  output logic           I2S_Underrun_Intr_o,
  output logic           I2S_TX_Busy_o,
  output logic           I2S_CLK_o,
  output logic           I2S_WS_CLK_o,
  output logic           I2S_DOUT_o
);
  localparam int unsigned FW    = 2 * DATA_WIDTH;
  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned PW    = $clog2(FW);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic             dout_q, dout_d;
  logic             busy_q;
  logic             ur_q, ur_d;
  logic [FW-1:0]    sh_q, sh_d;
  logic [PW-1:0]    p_q, p_d, p_inc;
  logic [FW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             tick, fall, wrap, load, push_ok, pop;
  logic [FW-1:0]    ur_frame, load_frame;

`ifdef I2S_TX_HOLD_LAST_EN
  logic [FW-1:0] last_q, last_d;

  always_comb last_d = pop ? mem_q[rd_q] : last_q;

  always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
    if (!RST_IP_N_i) last_q <= '0;
    else             last_q <= last_d;
  end

  assign ur_frame = last_q;
`else
  assign ur_frame = '0;
`endif

  // A fall event is the divider terminal count while the bit clock is high.
  assign tick       = (div_q == DIV_W'(HALF - 1));
  assign fall       = tick & sck_q;
  assign wrap       = (p_q == PW'(FW - 1));
  assign p_inc      = wrap ? '0 : p_q + PW'(1);
  assign push_ok    = tx_if.TX_PUSH_i & ~full_q;
  assign pop        = load & ~empty_q;
  assign load_frame = empty_q ? ur_frame : mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    dout_d  = dout_q;
    sh_d    = sh_q;
    p_d     = p_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        sck_d  = 1'b0;
        ws_d   = 1'b0;
        dout_d = 1'b0;
        p_d    = '0;
        if (TX_EN_i) begin
          state_d = S_RUN;
          load    = 1'b1;
          sh_d    = load_frame;
        end
      end
      S_RUN, S_STOP: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        sck_d = sck_q ^ tick;
        if (fall) begin
          dout_d = sh_q[FW-1];
          p_d    = p_inc;
          ws_d   = (p_inc >= PW'(DATA_WIDTH));
          sh_d   = {sh_q[FW-2:0], 1'b0};
          if (state_q == S_STOP) begin
            state_d = S_IDLE;
            dout_d  = 1'b0;
            ws_d    = 1'b0;
            p_d     = '0;
          end else if (wrap) begin
            // Old MSB (right LSB) is already in dout_d; the reload only replaces sh.
            if (TX_EN_i) begin
              load = 1'b1;
              sh_d = load_frame;
            end else begin
              state_d = S_STOP;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a push while full is dropped regardless of a same-cycle pop.
  always_comb begin
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop);
    cnt_d   = cnt_q + LW'(push_ok) - LW'(pop);
    full_d  = (cnt_d == LW'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
    ur_d    = (load & empty_q) | (ur_q & ~UNDERRUN_CLR_i);
  end

  always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
    if (!RST_IP_N_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ur_q    <= 1'b0;
      sh_q    <= '0;
      p_q     <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      dout_q  <= dout_d;
      busy_q  <= (state_d != S_IDLE);
      ur_q    <= ur_d;
      sh_q    <= sh_d;
      p_q     <= p_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge CLK_IP_i) begin
    if (push_ok) mem_q[wr_q] <= tx_if.TX_DAT_i;
  end

  assign tx_if.TX_FULL_o  = full_q;
  assign tx_if.TX_EMPTY_o = empty_q;
  assign tx_if.TX_LEVEL_o = cnt_q;
  assign I2S_Underrun_Intr_o = ur_q;
  assign I2S_TX_Busy_o       = busy_q;
  assign I2S_CLK_o           = sck_q;
  assign I2S_WS_CLK_o        = ws_q;
  assign I2S_DOUT_o          = dout_q;
endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: a receiver-side monitor decodes SCK rises into words, compared
// against a queue model of the frame FIFO; honours I2S_TX_HOLD_LAST_EN like the design.
module tb_i2s_tx_master;
  localparam int unsigned DW = 16;
  localparam int unsigned CD = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned FW = 2 * DW;
  localparam int unsigned LW = $clog2(FD) + 1;
  localparam logic [FW-1:0] WS_EXP = {{DW{1'b0}}, {DW{1'b1}}};

  logic clk, rst_n, tx_en, clr;
  logic intr, busy, sck, ws, dout;

  i2s_tx_master_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) tx_if ();

  i2s_tx_master #(.DATA_WIDTH(DW), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .CLK_IP_i            (clk),
    .RST_IP_N_i          (rst_n),
    .tx_if               (tx_if.slave),
    .TX_EN_i             (tx_en),
    .UNDERRUN_CLR_i      (clr),
    .I2S_Underrun_Intr_o (intr),
    .I2S_TX_Busy_o       (busy),
    .I2S_CLK_o           (sck),
    .I2S_WS_CLK_o        (ws),
    .I2S_DOUT_o          (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [FW-1:0] mq[$];
  logic [FW-1:0] last_model = '0;
  bit            ur_model   = 1'b0;

  // Receiver-side monitor: {ws, dout} at every SCK rise, and the cycle gap between rises
  int cyc = 0;
  int last_rise = 0;
  logic sck_prev = 1'b0;
  logic [1:0] rises[$];
  int periods[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sck && !sck_prev) begin
      if (rises.size() > 0) periods.push_back(cyc - last_rise);
      last_rise = cyc;
      rises.push_back({ws, dout});
    end
    sck_prev = sck;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_load(output logic [FW-1:0] fr, output bit u);
    if (mq.size() != 0) begin
      fr = mq.pop_front();
      last_model = fr;
      u = 1'b0;
    end else begin
      u = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
      fr = last_model;
`else
      fr = '0;
`endif
    end
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    @(negedge clk);
    tx_if.TX_DAT_i  = d;
    tx_if.TX_PUSH_i = 1'b1;
    if (mq.size() < FD) mq.push_back(d);
    @(negedge clk);
    tx_if.TX_PUSH_i = 1'b0;
  endtask

  task automatic wait_rises(input int n);
    int i;
    i = 0;
    while (rises.size() < n && i < n * CD * 2 + 64) begin
      @(negedge clk);
      i++;
    end
    check("rise_wait", 64'(rises.size() >= n), 64'd1);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ur_model = 1'b0;
    check("intr_cleared", intr, 64'd0);
  endtask

  // Transmit nfr frames; TX_EN drops at p=10 of the last frame. Optional push/clear in the start cycle.
  task automatic session(input int nfr, input bit push_start, input logic [FW-1:0] pd, input bit clr_start);
    logic [FW-1:0] exp_fr[$];
    logic [FW-1:0] fr, word, wsw;
    logic [1:0]    r;
    bit            u, full_before, ur_after_start;
    int            lvl_after_start, bad, i;

    full_before = (mq.size() == FD);
    model_load(fr, u);
    exp_fr.push_back(fr);
    ur_model = u | (ur_model & ~clr_start);
    ur_after_start = ur_model;
    if (push_start && !full_before) mq.push_back(pd);
    lvl_after_start = mq.size();
    for (int k = 1; k < nfr; k++) begin
      model_load(fr, u);
      exp_fr.push_back(fr);
      ur_model = ur_model | u;
    end

    @(negedge clk);
    rises.delete();
    periods.delete();
    tx_en = 1'b1;
    tx_if.TX_PUSH_i = push_start;
    tx_if.TX_DAT_i  = pd;
    clr = clr_start;
    @(negedge clk);
    tx_if.TX_PUSH_i = 1'b0;
    clr = 1'b0;
    check("busy_after_start", busy, 64'd1);
    check("intr_after_load", intr, 64'(ur_after_start));
    check("level_after_start", tx_if.TX_LEVEL_o, 64'(lvl_after_start));

    wait_rises((nfr - 1) * FW + 11);
    tx_en = 1'b0;
    i = 0;
    while (busy && i < FW * CD * 2) begin
      @(negedge clk);
      i++;
    end
    check("idle_wait", busy, 64'd0);
    repeat (2 * CD) @(negedge clk);

    check("rise_count", rises.size(), 64'(nfr * FW + 1));
    if (rises.size() == nfr * FW + 1) begin
      r = rises[0];
      check("first_dout", r[0], 64'd0);
      r = rises[nfr * FW];
      check("stop_ws", r[1], 64'd0);
      for (int f = 0; f < nfr; f++) begin
        word = '0;
        wsw  = '0;
        for (int b = 0; b < FW; b++) begin
          r    = rises[f * FW + 1 + b];
          word = {word[FW-2:0], r[0]};
          r    = rises[f * FW + b];
          wsw  = {wsw[FW-2:0], r[1]};
        end
        check($sformatf("frame%0d_data", f), word, exp_fr[f]);
        check($sformatf("frame%0d_ws", f), wsw, WS_EXP);
      end
    end
    bad = 0;
    foreach (periods[j]) if (periods[j] != CD) bad++;
    check("sck_period_bad", bad, 64'd0);
    check("idle_pins", {sck, ws, dout, busy}, 64'd0);
    check("intr_end", intr, 64'(ur_model));
    check("level_end", tx_if.TX_LEVEL_o, 64'(mq.size()));
    check("empty_end", tx_if.TX_EMPTY_o, 64'(mq.size() == 0));
    check("full_end", tx_if.TX_FULL_o, 64'(mq.size() == FD));
  endtask

  typedef struct {
    bit            push;
    logic [FW-1:0] dat;
    bit            exp_full;
    bit            exp_empty;
    logic [LW-1:0] exp_level;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    logic [9:0] rst_exp;

    tbl[0] = '{1'b1, 32'h1111_0001, 1'b0, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 32'h2222_0002, 1'b0, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 32'h3333_0003, 1'b0, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 32'h4444_0004, 1'b1, 1'b0, 3'd4};
    tbl[4] = '{1'b1, 32'h5555_0005, 1'b1, 1'b0, 3'd4};
    tbl[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 3'd4};
    rst_exp = {6'b0, 1'b1, 3'b0};

    rst_n = 1'b1;
    tx_en = 1'b0;
    clr   = 1'b0;
    tx_if.TX_PUSH_i = 1'b0;
    tx_if.TX_DAT_i  = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {sck, ws, dout, busy, intr, tx_if.TX_FULL_o, tx_if.TX_EMPTY_o, tx_if.TX_LEVEL_o},
          64'(rst_exp));
    rst_n = 1'b1;

    // Single frame, bit order and WS timing
    push_frame(32'hA5A5_3C3C);
    session(1, 1'b0, '0, 1'b0);

    // Fill to full with enable low, fifth push dropped, then drain in order
    foreach (tbl[i]) begin
      @(negedge clk);
      tx_if.TX_PUSH_i = tbl[i].push;
      tx_if.TX_DAT_i  = tbl[i].dat;
      if (tbl[i].push && mq.size() < FD) mq.push_back(tbl[i].dat);
      @(negedge clk);
      tx_if.TX_PUSH_i = 1'b0;
      check($sformatf("fifo_status_row%0d", i), {tx_if.TX_FULL_o, tx_if.TX_EMPTY_o, tx_if.TX_LEVEL_o},
            64'({tbl[i].exp_full, tbl[i].exp_empty, tbl[i].exp_level}));
    end
    session(4, 1'b0, '0, 1'b0);

    // Underrun, clear coincident with a new underrun, then plain clear
    session(1, 1'b0, '0, 1'b0);
    session(1, 1'b0, '0, 1'b1);
    clr_pulse();

    // Push and pop in the same cycle at level 2, then at full
    push_frame(32'hCAFE_0001);
    push_frame(32'hCAFE_0002);
    session(1, 1'b1, 32'hCAFE_0003, 1'b0);
    push_frame(32'hCAFE_0004);
    push_frame(32'hCAFE_0005);
    session(1, 1'b1, 32'hDEAD_DEAD, 1'b0);

    // Mid-frame reset at p=20 clears everything asynchronously
    @(negedge clk);
    rises.delete();
    tx_en = 1'b1;
    wait_rises(21);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {sck, ws, dout, busy, intr, tx_if.TX_FULL_o, tx_if.TX_EMPTY_o, tx_if.TX_LEVEL_o},
             64'(rst_exp));
    tx_en = 1'b0;
    mq.delete();
    last_model = '0;
    ur_model   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(32'h0F0F_8001);
    session(1, 1'b0, '0, 1'b0);

    // Randomized sessions
    for (int it = 0; it < 6; it++) begin
      int np;
      np = int'($urandom_range(0, FD + 1));
      for (int j = 0; j < np; j++) push_frame(FW'($urandom));
      session(int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), FW'($urandom),
              bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) clr_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
